// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - framed serial generator: preamble, MSB-first payload, one-cycle gap.
module sequence_generator #(
   parameter int                  PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1010,
   parameter int                  DATA_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              out,
   output logic              ready,
   output logic              busy,
   output logic              done
);

   localparam int MAX_LEN = (PAT_LEN > DATA_W) ? PAT_LEN : DATA_W;
   localparam int CNT_W   = $clog2(MAX_LEN) + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      GAP      = 2'd3
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [DATA_W-1:0]   shreg, shreg_n;
   logic                out_n, done_n;
   logic [PAT_LEN-1:0]  pat_shift;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         out   <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         shreg <= shreg_n;
         out   <= out_n;
         done  <= done_n;
      end
   end

   // out and done are registered, so they are derived from the next-state values.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      shreg_n   = shreg;
      out_n     = 1'b0;
      done_n    = 1'b0;
      pat_shift = '0;

      case (state)
         IDLE, GAP: begin
            if (start) begin
               state_n = PREAMBLE;
               cnt_n   = '0;
               shreg_n = data_in;
            end else begin
               state_n = IDLE;
            end
         end
         PREAMBLE: begin
            if (cnt == CNT_W'(PAT_LEN - 1)) begin
               state_n = DATA;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == CNT_W'(DATA_W - 1)) begin
               state_n = GAP;
               cnt_n   = '0;
            end else begin
               cnt_n   = cnt + 1'b1;
               shreg_n = shreg << 1;
            end
         end
         default: state_n = IDLE;
      endcase

      pat_shift = PATTERN << cnt_n;
      case (state_n)
         PREAMBLE: out_n = pat_shift[PAT_LEN-1];
         DATA:     out_n = shreg_n[DATA_W-1];
         default:  out_n = 1'b0;
      endcase
      done_n = (state_n == GAP);
   end

   assign ready = (state == IDLE) || (state == GAP);
   assign busy  = (state != IDLE);

endmodule
